mul_div_unit: RTL

- Iterative multiply/divide unit for the MIPS core; consumes RD1 (rs) and RD2 (rt) from the register file.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the result in architectural HI/LO registers.
- Asserts busy so the control path stalls instruction fetch and decode.
- Also services MTHI/MTLO writes; HI/LO are always readable, for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mdu_datapath.sv | 97 +++++++++
 rtl/mul_div_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mdu_pkg;

    localparam int MDU_WIDTH   = 32;
    localparam int MDU_LATENCY = MDU_WIDTH + 1;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control path and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: busy from the unit stalls the control path; start is dropped while busy.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_datapath.sv
// Shift-add multiplier / restoring divider on operand magnitudes with sign fix-up on the result.
// Latency: one step per strobe; WIDTH steps after load give the final result.
// Backpressure: none; sequencing is entirely owned by the controlling FSM.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // acc_q: running product high half / partial remainder.
    // q_q:   multiplier being shifted out / dividend shifting into quotient.
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic             is_div_q;
    logic             neg_main_q;
    logic             neg_rem_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_low;
    logic               div_ok;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign sign_a = op_is_signed(op) & rs_val[WIDTH-1];
    assign sign_b = op_is_signed(op) & rt_val[WIDTH-1];
    assign mag_a  = sign_a ? -rs_val : rs_val;
    assign mag_b  = sign_b ? -rt_val : rt_val;

    // One iteration of either algorithm. The divide trial subtract is done on
    // WIDTH bits: the bit shifted out of acc_q forces a subtract, and the
    // true difference is then always below the divisor so WIDTH bits suffice.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
        div_low = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
        div_ok  = acc_q[WIDTH-1] | (div_low >= m_q);
        div_sub = div_low - m_q;
    end

    // Operand capture on load, then one shift-add or shift-subtract per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (load) begin
            acc_q      <= '0;
            q_q        <= mag_a;
            m_q        <= mag_b;
            is_div_q   <= op_is_div(op);
            // Divide by zero keeps the all-ones quotient unsigned.
            neg_main_q <= (sign_a ^ sign_b) & ~(op_is_div(op) & (rt_val == '0));
            neg_rem_q  <= sign_a;
        end else if (step) begin
            if (is_div_q) begin
                acc_q <= div_ok ? div_sub : div_low;
                q_q   <= {q_q[WIDTH-2:0], div_ok};
            end else begin
                acc_q <= mul_sum[WIDTH:1];
                q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
            end
        end
    end

    // Sign correction and HI/LO placement of the finished magnitudes.
    always_comb begin
        prod     = {acc_q, q_q};
        prod_fix = neg_main_q ? -prod : prod;
        if (is_div_q) begin
            res_hi = neg_rem_q  ? -acc_q : acc_q;
            res_lo = neg_main_q ? -q_q   : q_q;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU iteratively, plus MTHI/MTLO writes.
// Latency: WIDTH+1 cycles busy after the start edge; done pulses the cycle after.
// Backpressure: busy stalls fetch/decode; start and MTHI/MTLO are ignored while busy.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             dp_load;
    logic             dp_step;
    logic             res_we;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    mdu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (dp_load),
        .step   (dp_step),
        .op     (bus.op),
        .rs_val (bus.rs_val),
        .rt_val (bus.rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state_q;
        dp_load = 1'b0;
        dp_step = 1'b0;
        res_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dp_load = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                dp_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration counter: loaded with WIDTH-1 so CALC lasts exactly WIDTH cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (dp_load) begin
            cnt_q <= CNT_W'(WIDTH - 1);
        end else if (dp_step) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // HI/LO: result write on FIX exit, otherwise MTHI/MTLO only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (res_we) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if (state_q == IDLE) begin
            if (bus.hi_we) hi_q <= bus.wd;
            if (bus.lo_we) lo_q <= bus.wd;
        end
    end

    // done marks the first cycle HI/LO show a new result, already back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= res_we;
        end
    end

endmodule
